// File: rtl/reg_writeback.sv
// reg_writeback -- register-file writeback arbiter with a load-return FIFO.
//
// Each cycle at most one register-file write is produced. The execute result
// always has priority. Otherwise the head of the load-return FIFO is retired.
// An execute write to register R squashes any older queued load to R, and any
// same-cycle accepted load to R. A squashed entry still drains from the FIFO,
// but it takes one idle output cycle and produces no write.
//
// A per-register pending scoreboard tracks loads that have been issued but not
// yet written back or squashed.
//
// Optional feature, macro WB_BYPASS_EN: an accepted load sees no execute write
// and an empty FIFO. In that case it goes straight to the output registers and
// does not occupy a FIFO slot.
//
// Ports:
//   clk, Nrst                  clock, synchronous active-low reset
//   ex_valid/ex_reg/ex_data    execute result (no backpressure)
//   mem_valid/mem_reg/mem_data load return, accepted on mem_valid && mem_ready
//   mem_ready                  FIFO has room (and not in reset)
//   ld_issue/ld_reg            load issued; marks ld_reg pending
//   write_req/write/write_data registered register-file write port
//   pending                    outstanding-load scoreboard
//   fifo_count                 FIFO occupancy, squashed entries included
module reg_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        Nrst,
  input  logic        ex_valid,
  input  logic [3:0]  ex_reg,
  input  logic [31:0] ex_data,
  input  logic        mem_valid,
  input  logic [3:0]  mem_reg,
  input  logic [31:0] mem_data,
  output logic        mem_ready,
  input  logic        ld_issue,
  input  logic [3:0]  ld_reg,
  output logic        write_req,
  output logic [3:0]  write,
  output logic [31:0] write_data,
  output logic [15:0] pending,
  output logic [3:0]  fifo_count
);

  localparam int PW = $clog2(DEPTH);

  // FIFO storage. A slot's valid bit is cleared when the slot is popped, so an
  // unoccupied slot can never match a squash compare.
  logic [DEPTH-1:0][3:0]  ent_reg_q;
  logic [DEPTH-1:0][31:0] ent_data_q;
  logic [DEPTH-1:0]       ent_vld_q, ent_vld_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [3:0]             cnt_q, cnt_d;

  logic        wr_req_q, wr_req_d;
  logic [3:0]  wr_idx_q, wr_idx_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [15:0] pend_q, pend_d, pend_clr, pend_set;

  logic             accept, fifo_empty, pop, push, bypass, mem_sq;
  logic [DEPTH-1:0] sq_hit;

  assign mem_ready  = (cnt_q < 4'(DEPTH)) && Nrst;
  assign accept     = mem_valid && mem_ready;
  assign fifo_empty = (cnt_q == 4'd0);
  assign pop        = !ex_valid && !fifo_empty;

`ifdef WB_BYPASS_EN
  assign bypass = !ex_valid && fifo_empty && accept;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  // Loads in the FIFO are always older than the concurrent execute result,
  // so an execute write to R makes every live queued load to R obsolete.
  for (genvar i = 0; i < DEPTH; i++) begin : g_sq
    assign sq_hit[i] = ex_valid && ent_vld_q[i] && (ent_reg_q[i] == ex_reg);
  end
  assign mem_sq = ex_valid && accept && (mem_reg == ex_reg);

  // Output source selection and scoreboard clears.
  always_comb begin
    wr_req_d  = 1'b0;
    wr_idx_d  = wr_idx_q;
    wr_data_d = wr_data_q;
    pend_clr  = '0;
    if (ex_valid) begin
      wr_req_d  = 1'b1;
      wr_idx_d  = ex_reg;
      wr_data_d = ex_data;
    end else if (pop) begin
      // A squashed head drains silently.
      if (ent_vld_q[rd_ptr_q]) begin
        wr_req_d                     = 1'b1;
        wr_idx_d                     = ent_reg_q[rd_ptr_q];
        wr_data_d                    = ent_data_q[rd_ptr_q];
        pend_clr[ent_reg_q[rd_ptr_q]] = 1'b1;
      end
    end else if (bypass) begin
      wr_req_d          = 1'b1;
      wr_idx_d          = mem_reg;
      wr_data_d         = mem_data;
      pend_clr[mem_reg] = 1'b1;
    end
    if ((|sq_hit) || mem_sq) pend_clr[ex_reg] = 1'b1;
  end

  // A same-cycle issue to the same register overrides the clear.
  assign pend_set = ld_issue ? (16'd1 << ld_reg) : 16'd0;
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_comb begin
    ent_vld_d = ent_vld_q & ~sq_hit;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    if (pop) begin
      ent_vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d            = rd_ptr_q + 1'b1;
    end
    if (push) begin
      ent_vld_d[wr_ptr_q] = !mem_sq;
      wr_ptr_d            = wr_ptr_q + 1'b1;
    end
    cnt_d = cnt_q + {3'd0, push} - {3'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (!Nrst) begin
      ent_vld_q <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_req_q  <= 1'b0;
      wr_idx_q  <= '0;
      wr_data_q <= '0;
      pend_q    <= '0;
    end else begin
      ent_vld_q <= ent_vld_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      wr_req_q  <= wr_req_d;
      wr_idx_q  <= wr_idx_d;
      wr_data_q <= wr_data_d;
      pend_q    <= pend_d;
    end
  end

  // Payload needs no reset; occupancy is governed by the valid bits and count.
  always_ff @(posedge clk) begin
    if (push) begin
      ent_reg_q[wr_ptr_q]  <= mem_reg;
      ent_data_q[wr_ptr_q] <= mem_data;
    end
  end

  assign write_req  = wr_req_q;
  assign write      = wr_idx_q;
  assign write_data = wr_data_q;
  assign pending    = pend_q;
  assign fifo_count = cnt_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback.
//
// The stimulus process drives one cycle at a time. It keeps a queue-level
// model of the load FIFO and the pending bits, and it records each expected
// write, stamped with the cycle in which it must appear. A negedge monitor
// compares every DUT write against the oldest expected write.
module tb_reg_writeback;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        Nrst;
  logic        ex_valid, mem_valid, ld_issue;
  logic [3:0]  ex_reg, mem_reg, ld_reg;
  logic [31:0] ex_data, mem_data;
  logic        mem_ready, write_req;
  logic [3:0]  write, fifo_count;
  logic [31:0] write_data;
  logic [15:0] pending;

  reg_writeback #(.DEPTH(DEPTH)) dut (
    .clk(clk), .Nrst(Nrst),
    .ex_valid(ex_valid), .ex_reg(ex_reg), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data),
    .mem_ready(mem_ready),
    .ld_issue(ld_issue), .ld_reg(ld_reg),
    .write_req(write_req), .write(write), .write_data(write_data),
    .pending(pending), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [3:0] r; logic [31:0] d; bit v; } ent_t;
  typedef struct { int c; logic [3:0] r; logic [31:0] d; } exp_t;
  ent_t mq[$];
  exp_t expq[$];
  bit [15:0] mpend = '0;
  bit rst_prev = 1'b0;
  int tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (expq.size() > 0 && expq[0].c < cyc) begin
      tests++; fails++;
      $display("FAIL missing_write: got none, want r%0d=%h (cycle %0d)", expq[0].r, expq[0].d, expq[0].c);
      void'(expq.pop_front());
    end
    if (write_req === 1'b1) begin
      if (expq.size() == 0 || expq[0].c != cyc) begin
        tests++; fails++;
        $display("FAIL spurious_write: got r%0d=%h, want no write (cycle %0d)", write, write_data, cyc);
      end else begin
        chk("write_idx", 32'(write), 32'(expq[0].r));
        chk("write_data", write_data, expq[0].d);
        void'(expq.pop_front());
      end
    end
  end

  task automatic expect_wr(input logic [3:0] r, input logic [31:0] d);
    expq.push_back('{cyc + 1, r, d});
  endtask

  // One clock: apply inputs, check state against the model, then advance the model.
  task automatic step(input bit n, input bit ev, input logic [3:0] er, input logic [31:0] ed,
                      input bit mv, input logic [3:0] mr, input logic [31:0] md,
                      input bit li, input logic [3:0] lr);
    bit rdy, acc;
    bit [15:0] clr;
    ent_t h;
    Nrst = n; ex_valid = ev; ex_reg = er; ex_data = ed;
    mem_valid = mv; mem_reg = mr; mem_data = md; ld_issue = li; ld_reg = lr;
    #1;
    rdy = n && (mq.size() < DEPTH);
    chk("mem_ready", 32'(mem_ready), 32'(rdy));
    chk("pending", 32'(pending), 32'(mpend));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    if (rst_prev) begin
      chk("rst_write_req", 32'(write_req), 32'd0);
      chk("rst_write", 32'(write), 32'd0);
      chk("rst_write_data", write_data, 32'd0);
    end
    rst_prev = !n;
    if (!n) begin
      mq.delete();
      mpend = '0;
    end else begin
      acc = mv && rdy;
      clr = '0;
      if (ev) begin
        expect_wr(er, ed);
        foreach (mq[i]) if (mq[i].v && mq[i].r == er) begin mq[i].v = 1'b0; clr[er] = 1'b1; end
        if (acc) begin
          mq.push_back('{mr, md, mr != er});
          if (mr == er) clr[er] = 1'b1;
        end
      end else if (mq.size() > 0) begin
        h = mq.pop_front();
        if (h.v) begin expect_wr(h.r, h.d); clr[h.r] = 1'b1; end
        if (acc) mq.push_back('{mr, md, 1'b1});
      end else if (acc) begin
`ifdef WB_BYPASS_EN
        expect_wr(mr, md);
        clr[mr] = 1'b1;
`else
        mq.push_back('{mr, md, 1'b1});
`endif
      end
      mpend &= ~clr;
      if (li) mpend[lr] = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    int k;
    bit acc;
    Nrst = 0; ex_valid = 0; ex_reg = 0; ex_data = 0;
    mem_valid = 0; mem_reg = 0; mem_data = 0; ld_issue = 0; ld_reg = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_prev = 1'b1;

    // Basic execute write.
    step(1, 1, 3, 32'h12345678, 0, 0, 0, 0, 0);
    idle(2);

    // Single load: issue, return, writeback.
    step(1, 0, 0, 0, 0, 0, 0, 1, 5);
    idle(1);
    step(1, 0, 0, 0, 1, 5, 32'hCAFEF00D, 0, 0);
    idle(3);

    // Execute busy for 6 cycles while 5 loads are offered; FIFO fills to DEPTH.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 4'(i));
    k = 0;
    for (int c = 0; c < 6; c++) begin
      acc = (k < 5) && (mq.size() < DEPTH);
      step(1, 1, 4'(8 + c), $urandom, k < 5, 4'(k), 32'hA000 + k, 0, 0);
      if (acc) k++;
    end
    while (k < 5) begin
      acc = mq.size() < DEPTH;
      step(1, 0, 0, 0, 1, 4'(k), 32'hA000 + k, 0, 0);
      if (acc) k++;
    end
    idle(6);

    // Queued load to r7 squashed by an execute write to r7.
    step(1, 0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 1, 1, 32'h55, 1, 7, 32'hDEAD0007, 0, 0);
    step(1, 1, 7, 32'h1, 0, 0, 0, 0, 0);
    idle(3);

    // Reissue to r2 in the cycle its load retires keeps pending[2] set.
    step(1, 0, 0, 0, 0, 0, 0, 1, 2);
    step(1, 1, 9, 32'h99, 1, 2, 32'h22222222, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 1, 2);
    chk("reissue_pending2", 32'(pending[2]), 32'd1);
    step(1, 0, 0, 0, 1, 2, 32'h2222BBBB, 0, 0);
    idle(3);

    // Reset with three loads queued.
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 0, 1, 4'(10 + i));
    for (int i = 0; i < 3; i++) step(1, 1, 0, 32'h0F0F, 1, 4'(10 + i), 32'hB000 + i, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(5);

    // Random traffic with occasional resets.
    for (int i = 0; i < 800; i++)
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 1) == 1), 4'($urandom), $urandom,
           ($urandom_range(0, 1) == 1), 4'($urandom), $urandom,
           ($urandom_range(0, 2) == 0), 4'($urandom));
    idle(12);
    chk("expected_drained", 32'(expq.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
